// File: rtl/alu_rmw_if.sv
// alu_rmw_if: request handshake and memory bus between the decoder/bus side and the RMW sequencer
//   start/op/addr   request from the decoder (op/addr latched on an accepted start)
//   busy/done       sequencer status back to the decoder
//   bus_addr/bus_rw memory address and direction (1 = read, 0 = write)
//   bus_data_in     read data from memory
//   bus_data_out    write data to memory
//   master = environment side, slave = sequencer side
interface alu_rmw_if;
    logic        start;
    logic [2:0]  op;
    logic [15:0] addr;
    logic        busy;
    logic        done;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    modport master (output start, op, addr, bus_data_in, input busy, done, bus_addr, bus_rw, bus_data_out);
    modport slave  (input start, op, addr, bus_data_in, output busy, done, bus_addr, bus_rw, bus_data_out);
endinterface

// File: rtl/alu_rmw_sequencer.sv
// alu_rmw_sequencer: 6502 read-modify-write sequencer (read, dummy write, result write) around an external ALU
//   clk, rst_n            clock and synchronous active-low reset
//   bus                   request handshake + memory bus (alu_rmw_if.slave)
//   alu_op_o/alu_a/alu_b  operands to the ALU (alu_b is always 0)
//   alu_result/alu_flags  ALU outputs
//   flags_we/mask/out     C/Z/N update for the status register, valid in the WRITE cycle
//   result                last ALU result, held until the next operation
module alu_rmw_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    alu_rmw_if.slave   bus,
    output logic [2:0] alu_op_o,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_flags,
    output logic       flags_we,
    output logic [7:0] flags_mask,
    output logic [7:0] flags_out,
    output logic [7:0] result
);
    localparam int CARRY_FLAG    = 0;
    localparam int ZERO_FLAG     = 1;
    localparam int NEGATIVE_FLAG = 7;

    typedef enum logic [1:0] {IDLE, READ, DUMMY, WRITE} state_t;

    state_t      state, nxt;
    logic [2:0]  op_q;
    logic [15:0] addr_q;
    logic [7:0]  operand;
    logic [7:0]  result_q;
    logic        c_q, z_q, n_q;

    // only C and N are taken from the ALU; the remaining flag bits are dropped
    logic unused_alu_flags;
    assign unused_alu_flags = ^alu_flags[6:1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            operand  <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.start) begin
                op_q   <= bus.op;
                addr_q <= bus.addr;
            end
            if (state == READ)
                operand <= bus.bus_data_in;
            if (state == DUMMY) begin
                result_q <= alu_result;
                c_q      <= alu_flags[CARRY_FLAG];
                n_q      <= alu_flags[NEGATIVE_FLAG];
                // Z is derived locally rather than trusted from the ALU
                z_q      <= (alu_result == 8'h00);
            end
        end
    end

    always_comb begin
        nxt = state;
        nxt = (state == IDLE)  ? (bus.start ? READ : IDLE) :
              (state == READ)  ? DUMMY :
              (state == DUMMY) ? WRITE : IDLE;
    end

    always_comb begin
        flags_mask = '0;
        flags_out  = '0;
        if (state == WRITE) begin
            flags_mask[CARRY_FLAG]    = 1'b1;
            flags_mask[ZERO_FLAG]     = 1'b1;
            flags_mask[NEGATIVE_FLAG] = 1'b1;
            flags_out[CARRY_FLAG]     = c_q;
            flags_out[ZERO_FLAG]      = z_q;
            flags_out[NEGATIVE_FLAG]  = n_q;
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == WRITE);
    assign bus.bus_rw       = !(state == DUMMY || state == WRITE);
    assign bus.bus_addr     = addr_q;
    assign bus.bus_data_out = (state == WRITE) ? result_q : operand;
    assign alu_op_o         = op_q;
    assign alu_a            = operand;
    assign alu_b            = 8'h00;
    assign flags_we         = (state == WRITE);
    assign result           = result_q;
endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// tb_alu_rmw_sequencer: self-checking bench with memory and ALU models and a bus-cycle scoreboard
module tb_alu_rmw_sequencer;
    localparam logic [2:0] ASL = 3'd0, LSR = 3'd1, ROL = 3'd2, ROR = 3'd3, INC = 3'd4, DEC = 3'd5, NOP = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rmw_if bus();
    logic [2:0] alu_op_o;
    logic [7:0] alu_a, alu_b, alu_result, alu_flags, flags_mask, flags_out, result;
    logic       flags_we;

    alu_rmw_sequencer dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .alu_op_o(alu_op_o), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .flags_we(flags_we), .flags_mask(flags_mask), .flags_out(flags_out), .result(result)
    );

    logic [7:0] mem [0:65535];
    assign bus.bus_data_in = mem[bus.bus_addr];

    // ALU model; its Z bit is deliberately inverted and unused bits set so the DUT must ignore them
    logic       m_c;
    logic [7:0] m_r;
    always_comb begin
        m_c = 1'b0;
        m_r = 8'h00;
        case (alu_op_o)
            ASL: {m_c, m_r} = {alu_a, 1'b0};
            LSR: {m_r, m_c} = {1'b0, alu_a};
            ROL: {m_c, m_r} = {alu_a, 1'b0};
            ROR: {m_r, m_c} = {1'b0, alu_a};
            INC: m_r = alu_a + 8'd1;
            DEC: m_r = alu_a - 8'd1;
            default: m_r = 8'h00;
        endcase
        alu_result = m_r;
        alu_flags  = {m_r[7], 5'b11111, m_r != 8'h00, m_c};
    end

    typedef struct packed {
        logic        rw;
        logic [15:0] a;
        logic [7:0]  d;
        logic        dn;
        logic        we;
        logic [7:0]  m;
        logic [7:0]  f;
    } acc_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [7:0]  din;
        logic [7:0]  res;
        logic        c, z, n;
    } vec_t;

    acc_t exp_q[$];
    int   done_q[$];
    int   checks = 0, failures = 0, cyc = 0;
    bit   mon_en = 1'b0;
    acc_t mon_e, mon_a;
    vec_t vecs[10];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        if (bus.busy) begin
            if (bus.done) done_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bus_cycle actual=busy required=idle @%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = {bus.bus_rw, bus.bus_addr, bus.bus_rw ? 8'h00 : bus.bus_data_out,
                         bus.done, flags_we, flags_mask, flags_out};
                chk("bus_cycle", 64'(mon_a), 64'(mon_e));
            end
        end else
            chk("idle_outputs", {bus.bus_rw, bus.done, flags_we, flags_mask, alu_b}, {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
    end

    task automatic push_rd(input logic [15:0] a);
        exp_q.push_back({1'b1, a, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00});
    endtask

    task automatic push_dm(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({1'b0, a, d, 1'b0, 1'b0, 8'h00, 8'h00});
    endtask

    task automatic push_op(input vec_t v);
        push_rd(v.addr);
        push_dm(v.addr, v.din);
        exp_q.push_back({1'b0, v.addr, v.res, 1'b1, 1'b1, 8'h83, {v.n, 5'b0, v.z, v.c}});
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a);
        bus.start = 1'b1;
        bus.op    = op;
        bus.addr  = a;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.addr  = 16'h0000;
        vecs[0] = '{ASL, 16'h0200, 8'h81, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{ASL, 16'h0010, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{ASL, 16'h01FF, 8'h40, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{NOP, 16'h0123, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{LSR, 16'h2001, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{LSR, 16'h2002, 8'hFE, 8'h7F, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{INC, 16'hFFFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{DEC, 16'h8000, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{ROL, 16'h0055, 8'hC1, 8'h82, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{ROR, 16'hA5A5, 8'h03, 8'h01, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_state",
            {1'b0, bus.busy, bus.done, bus.bus_rw, flags_we, flags_mask, flags_out, bus.bus_addr,
             bus.bus_data_out, alu_op_o, alu_a, result},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 3'h0, 8'h00, 8'h00});
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            mem[vecs[i].addr] = vecs[i].din;
            push_op(vecs[i]);
            issue(vecs[i].op, vecs[i].addr);
            drain();
            chk("result_held", 64'(result), 64'(vecs[i].res));
        end

        // start held high across two operations: accepts only in IDLE, 4 cycles apart
        mem[16'h0300] = 8'h01;
        mem[16'h0301] = 8'hC0;
        push_op('{ASL, 16'h0300, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0});
        push_op('{ASL, 16'h0301, 8'hC0, 8'h80, 1'b1, 1'b0, 1'b1});
        done_q.delete();
        bus.start = 1'b1;
        bus.op    = ASL;
        bus.addr  = 16'h0300;
        @(negedge clk);
        bus.addr  = 16'h0301;
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        drain();
        chk("b2b_done_count", 64'(done_q.size()), 64'd2);
        if (done_q.size() == 2) chk("b2b_spacing", 64'(done_q[1] - done_q[0]), 64'd4);

        // reset asserted at the edge ending DUMMY, with start also high
        mem[16'h0400] = 8'h33;
        push_rd(16'h0400);
        push_dm(16'h0400, 8'h33);
        issue(ASL, 16'h0400);
        @(negedge clk);
        rst_n     = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        chk("reset_mid_op",
            {1'b0, bus.busy, bus.done, bus.bus_rw, flags_we, flags_mask, flags_out, bus.bus_addr,
             bus.bus_data_out, alu_op_o, alu_a, result},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 3'h0, 8'h00, 8'h00});
        chk("reset_queue", 64'(exp_q.size()), 64'd0);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", 64'(bus.busy), 64'd0);

        mem[16'h0401] = 8'h01;
        push_op('{ASL, 16'h0401, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0});
        issue(ASL, 16'h0401);
        drain();
        chk("after_reset_result", 64'(result), 64'h02);

        repeat (2) @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
